pwm_multi_channel: RTL

Parametrised successor to the 16-channel, 8-bit PWM peripheral. It is fed by the SPI register block and drives the chip output pins. It adds configurable channel count and counter width, a programmable period and clock prescaler, and per-channel duty cycles. Duty, period and prescale go through shadow registers that update glitch-free at a period boundary.

---
 rtl/pwm_multi_channel_if.sv | 52 +++++
 rtl/pwm_multi_channel.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_channel_if.sv
// ============================================================================
// Module   : pwm_multi_channel_if
// Brief    : Configuration/status bundle between the register block and the
//            multi-channel PWM. Adds align_center when PWM_CENTER_ALIGNED_EN
//            is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface pwm_multi_channel_if #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 8
);
    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [CNT_W-1:0]        period;
    logic [PRE_W-1:0]        prescale;
    logic                    update_req;
    logic [NUM_CH-1:0]       out;
    logic                    update_ack;
    logic                    period_start;
    logic [CNT_W-1:0]        cnt_o;

`ifdef PWM_CENTER_ALIGNED_EN
    logic                    align_center;

    modport master (
        output en_out, en_pwm, duty, period, prescale, update_req, align_center,
        input  out, update_ack, period_start, cnt_o
    );

    modport slave (
        input  en_out, en_pwm, duty, period, prescale, update_req, align_center,
        output out, update_ack, period_start, cnt_o
    );
`else
    modport master (
        output en_out, en_pwm, duty, period, prescale, update_req,
        input  out, update_ack, period_start, cnt_o
    );

    modport slave (
        input  en_out, en_pwm, duty, period, prescale, update_req,
        output out, update_ack, period_start, cnt_o
    );
`endif

endinterface

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// ============================================================================
// Module   : pwm_multi_channel
// Brief    : Parametrised multi-channel PWM with prescaler, programmable period
//            and shadowed duty/period/prescale reloaded at period boundaries.
//            Optional center-aligned counting via PWM_CENTER_ALIGNED_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pwm_multi_channel #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8,
    parameter int PRE_W  = 8
) (
    input wire                 clk,
    input wire                 rst,
    pwm_multi_channel_if.slave bus
);

    localparam logic [CNT_W-1:0] C_DUTY_FULL = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);
    localparam logic [PRE_W-1:0] C_PRE_ONE   = PRE_W'(1);

    logic [PRE_W-1:0]        r_pre_cnt;
    logic [PRE_W-1:0]        r_prescale_sh;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        r_period_sh;
    logic [NUM_CH*CNT_W-1:0] r_duty_sh;
    logic                    r_pending;
    logic                    r_update_ack;
    logic                    r_wrap;
    logic                    r_period_start;
    logic [NUM_CH-1:0]       r_out;

    logic                    w_tick;
    logic                    w_boundary;
    logic                    w_load;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [NUM_CH-1:0]       w_pwm;

    assign w_tick = (r_pre_cnt == r_prescale_sh);

`ifdef PWM_CENTER_ALIGNED_EN
    logic r_align_sh;
    logic r_dir_down;
    logic w_dir_next;
    logic w_center;

    // A zero period cannot count up and down, so it falls back to edge mode.
    assign w_center = r_align_sh && (r_period_sh != '0);

    always_comb begin
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_down;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (!w_center) begin
                w_dir_next = 1'b0;
                if (r_cnt == r_period_sh) begin
                    w_cnt_next = '0;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end else if (!r_dir_down) begin
                if (r_cnt == r_period_sh) begin
                    if (r_cnt == C_CNT_ONE) begin
                        w_cnt_next = '0;
                        w_boundary = 1'b1;
                    end else begin
                        w_cnt_next = r_cnt - C_CNT_ONE;
                        w_dir_next = 1'b1;
                    end
                end else begin
                    w_cnt_next = r_cnt + C_CNT_ONE;
                end
            end else begin
                // Reaching zero on the way down closes the period.
                if ((r_cnt == C_CNT_ONE) || (r_cnt == '0)) begin
                    w_cnt_next = '0;
                    w_dir_next = 1'b0;
                    w_boundary = 1'b1;
                end else begin
                    w_cnt_next = r_cnt - C_CNT_ONE;
                end
            end
        end
    end
`else
    always_comb begin
        w_cnt_next = r_cnt;
        w_boundary = 1'b0;
        if (w_tick) begin
            if (r_cnt == r_period_sh) begin
                w_cnt_next = '0;
                w_boundary = 1'b1;
            end else begin
                w_cnt_next = r_cnt + C_CNT_ONE;
            end
        end
    end
`endif

    // A request landing in the boundary cycle itself is honoured immediately.
    assign w_load = w_boundary && (r_pending || bus.update_req);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] w_duty_i;
        assign w_duty_i = r_duty_sh[i*CNT_W +: CNT_W];
        assign w_pwm[i] = (w_duty_i == C_DUTY_FULL) || (r_cnt < w_duty_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt      <= '0;
            r_cnt          <= '0;
            r_prescale_sh  <= '0;
            r_period_sh    <= '0;
            r_duty_sh      <= '0;
            r_pending      <= 1'b1;
            r_update_ack   <= 1'b0;
            r_wrap         <= 1'b0;
            r_period_start <= 1'b0;
            r_out          <= '0;
        end else begin
            r_pre_cnt <= w_tick ? '0 : (r_pre_cnt + C_PRE_ONE);
            r_cnt     <= w_cnt_next;

            if (w_load) begin
                r_duty_sh     <= bus.duty;
                r_period_sh   <= bus.period;
                r_prescale_sh <= bus.prescale;
                r_pending     <= 1'b0;
            end else if (bus.update_req) begin
                r_pending     <= 1'b1;
            end

            r_update_ack <= w_load;
            // Two stages so the pulse lines up with the first cnt=0 output.
            r_wrap         <= w_boundary;
            r_period_start <= r_wrap;
            r_out          <= bus.en_out & (~bus.en_pwm | w_pwm);
        end
    end

`ifdef PWM_CENTER_ALIGNED_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_sh <= 1'b0;
            r_dir_down <= 1'b0;
        end else begin
            r_dir_down <= w_load ? 1'b0 : w_dir_next;
            if (w_load) begin
                r_align_sh <= bus.align_center;
            end
        end
    end
`endif

    assign bus.out          = r_out;
    assign bus.update_ack   = r_update_ack;
    assign bus.period_start = r_period_start;
    assign bus.cnt_o        = r_cnt;

endmodule

`default_nettype wire
